// File: rtl/iq_loopback_pkg.sv
// iq_loopback_pkg
// Shared definitions for the IQ loopback switch.
// Contents:
//   MODE_*     - cfg_mode encodings (codes 2 and 3 both select the zero stream)
//   sw_state_t - switch FSM state encoding
package iq_loopback_pkg;

    localparam logic [1:0] MODE_ADC  = 2'd0;
    localparam logic [1:0] MODE_LOOP = 2'd1;
    localparam logic [1:0] MODE_ZERO = 2'd2;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_MUTE = 1'b1
    } sw_state_t;

endpackage

// File: rtl/iq_delay_line.sv
// iq_delay_line
// Circular buffer of transmit IQ samples with a programmable read tap.
// Ports:
//   clk_32M768, rst_32M768 - clock, async active-high reset (clears pointer and fill only)
//   wr_en, wr_i, wr_q      - DAC sample written on every wr_en
//   rd_delay               - tap distance in samples; 0 bypasses the buffer to the current input
//   rd_i, rd_q             - combinational read of the sample written rd_delay writes earlier,
//                            or 0 when that entry has not been written since reset
module iq_delay_line #(
    parameter int DATA_W    = 12,
    parameter int DELAY_MAX = 64,
    parameter int DLY_W     = $clog2(DELAY_MAX)
) (
    input  logic              clk_32M768,
    input  logic              rst_32M768,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_i,
    input  logic [DATA_W-1:0] wr_q,
    input  logic [DLY_W-1:0]  rd_delay,
    output logic [DATA_W-1:0] rd_i,
    output logic [DATA_W-1:0] rd_q
);

    logic [2*DATA_W-1:0] mem [DELAY_MAX];
    logic [DLY_W-1:0]    wr_ptr;
    logic [DLY_W:0]      fill;
    logic [DLY_W-1:0]    rd_addr;

    // Storage has no reset; the fill counter is what hides stale history.
    always_ff @(posedge clk_32M768) begin
        if (wr_en) begin
            mem[wr_ptr] <= {wr_i, wr_q};
        end
    end

    // fill counts writes since reset (saturating) so a tap can tell whether
    // its entry is real.
    always_ff @(posedge clk_32M768 or posedge rst_32M768) begin
        if (rst_32M768) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (fill != (DLY_W+1)'(DELAY_MAX)) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // wr_ptr is the slot about to be written, so wr_ptr-d holds the sample
    // from d writes ago; it exists once at least d prior writes happened.
    always_comb begin
        rd_addr = wr_ptr - rd_delay;
        rd_i    = '0;
        rd_q    = '0;
        if (rd_delay == '0) begin
            rd_i = wr_i;
            rd_q = wr_q;
        end else if (fill >= {1'b0, rd_delay}) begin
            {rd_i, rd_q} = mem[rd_addr];
        end
    end

endmodule

// File: rtl/iq_loopback_switch.sv
// iq_loopback_switch
// Source selector at the Rx chain input: live ADC, delayed/attenuated DAC
// loopback, or zeros. Any mode/delay change mutes MUTE_LEN output samples.
// Ports:
//   clk_32M768, rst_32M768      - clock, async active-high reset
//   cfg_mode                    - 0 ADC, 1 loopback, 2/3 zero stream
//   cfg_delay                   - loopback delay in DAC samples
//   cfg_atten_shift             - arithmetic right shift on loopback data (unmonitored)
//   dac_valid/dac_i/dac_q       - transmit samples, always written to the delay line
//   adc_valid/adc_i/adc_q       - received samples
//   out_valid/out_i/out_q       - registered selected stream, one cycle latency
//   sw_busy                     - high while muting
module iq_loopback_switch
    import iq_loopback_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int DELAY_MAX = 64,
    parameter int MUTE_LEN  = 16,
    parameter int DLY_W     = $clog2(DELAY_MAX)
) (
    input  logic              clk_32M768,
    input  logic              rst_32M768,
    input  logic [1:0]        cfg_mode,
    input  logic [DLY_W-1:0]  cfg_delay,
    input  logic [3:0]        cfg_atten_shift,
    input  logic              dac_valid,
    input  logic [DATA_W-1:0] dac_i,
    input  logic [DATA_W-1:0] dac_q,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_i,
    input  logic [DATA_W-1:0] adc_q,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_i,
    output logic [DATA_W-1:0] out_q,
    output logic              sw_busy
);

    localparam int CNT_W = $clog2(MUTE_LEN + 1);

    sw_state_t          state;
    logic [CNT_W-1:0]   mute_cnt;
    logic [CNT_W-1:0]   cnt_eff;
    logic [1:0]         mode_q;
    logic [DLY_W-1:0]   delay_q;
    logic               init_q;
    logic               cfg_change;
    logic               muting;
    logic               src_valid;
    logic [DATA_W-1:0]  loop_i;
    logic [DATA_W-1:0]  loop_q;
    logic signed [DATA_W-1:0] atten_i;
    logic signed [DATA_W-1:0] atten_q;
    logic [DATA_W-1:0]  sel_i;
    logic [DATA_W-1:0]  sel_q;

    iq_delay_line #(
        .DATA_W    (DATA_W),
        .DELAY_MAX (DELAY_MAX),
        .DLY_W     (DLY_W)
    ) u_delay_line (
        .clk_32M768 (clk_32M768),
        .rst_32M768 (rst_32M768),
        .wr_en      (dac_valid),
        .wr_i       (dac_i),
        .wr_q       (dac_q),
        .rd_delay   (cfg_delay),
        .rd_i       (loop_i),
        .rd_q       (loop_q)
    );

    // The cfg inputs drive selection directly: outside a change cycle they
    // equal the active regs, and on a change cycle the new config must apply
    // at once. init_q suppresses change detection on the first edge after
    // reset, where the regs are just loaded.
    always_comb begin
        cfg_change = !init_q && ((cfg_mode != mode_q) || (cfg_delay != delay_q));
        muting     = cfg_change || (state == ST_MUTE);
        cnt_eff    = cfg_change ? CNT_W'(MUTE_LEN) : mute_cnt;
        src_valid  = (cfg_mode == MODE_LOOP) ? dac_valid : adc_valid;
        atten_i    = $signed(loop_i) >>> cfg_atten_shift;
        atten_q    = $signed(loop_q) >>> cfg_atten_shift;
        sel_i      = '0;
        sel_q      = '0;
        case (cfg_mode)
            MODE_ADC: begin
                sel_i = adc_i;
                sel_q = adc_q;
            end
            MODE_LOOP: begin
                sel_i = atten_i;
                sel_q = atten_q;
            end
            default: begin
                sel_i = '0;
                sel_q = '0;
            end
        endcase
    end

    // A change reloads the mute count; a valid sample in the same cycle is
    // already the first muted sample, so the later assignments override.
    always_ff @(posedge clk_32M768 or posedge rst_32M768) begin
        if (rst_32M768) begin
            state     <= ST_MUTE;
            mute_cnt  <= CNT_W'(MUTE_LEN);
            mode_q    <= '0;
            delay_q   <= '0;
            init_q    <= 1'b1;
            out_valid <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
            sw_busy   <= 1'b1;
        end else begin
            init_q    <= 1'b0;
            out_valid <= src_valid;
            if (init_q || cfg_change) begin
                mode_q  <= cfg_mode;
                delay_q <= cfg_delay;
            end
            if (cfg_change) begin
                state    <= ST_MUTE;
                mute_cnt <= CNT_W'(MUTE_LEN);
                sw_busy  <= 1'b1;
            end
            if (src_valid) begin
                if (muting) begin
                    out_i    <= '0;
                    out_q    <= '0;
                    mute_cnt <= cnt_eff - 1'b1;
                    if (cnt_eff == CNT_W'(1)) begin
                        state   <= ST_RUN;
                        sw_busy <= 1'b0;
                    end
                end else begin
                    out_i <= sel_i;
                    out_q <= sel_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_iq_loopback_switch.sv
// tb_iq_loopback_switch
// Randomized scoreboard bench for iq_loopback_switch. Stimulus computes the
// expected output from a sample-history model and queues it; a monitor on
// the falling edge pops and compares whenever out_valid is high.
module tb_iq_loopback_switch;
    import iq_loopback_pkg::*;

    localparam int DATA_W    = 12;
    localparam int DELAY_MAX = 64;
    localparam int MUTE_LEN  = 16;
    localparam int DLY_W     = 6;

    logic              clk_32M768;
    logic              rst_32M768;
    logic [1:0]        cfg_mode;
    logic [DLY_W-1:0]  cfg_delay;
    logic [3:0]        cfg_atten_shift;
    logic              dac_valid;
    logic [DATA_W-1:0] dac_i;
    logic [DATA_W-1:0] dac_q;
    logic              adc_valid;
    logic [DATA_W-1:0] adc_i;
    logic [DATA_W-1:0] adc_q;
    logic              out_valid;
    logic [DATA_W-1:0] out_i;
    logic [DATA_W-1:0] out_q;
    logic              sw_busy;

    iq_loopback_switch #(
        .DATA_W    (DATA_W),
        .DELAY_MAX (DELAY_MAX),
        .MUTE_LEN  (MUTE_LEN)
    ) dut (
        .clk_32M768      (clk_32M768),
        .rst_32M768      (rst_32M768),
        .cfg_mode        (cfg_mode),
        .cfg_delay       (cfg_delay),
        .cfg_atten_shift (cfg_atten_shift),
        .dac_valid       (dac_valid),
        .dac_i           (dac_i),
        .dac_q           (dac_q),
        .adc_valid       (adc_valid),
        .adc_i           (adc_i),
        .adc_q           (adc_q),
        .out_valid       (out_valid),
        .out_i           (out_i),
        .out_q           (out_q),
        .sw_busy         (sw_busy)
    );

    initial clk_32M768 = 1'b0;
    always #5 clk_32M768 = ~clk_32M768;

    typedef struct {
        logic [DATA_W-1:0] i;
        logic [DATA_W-1:0] q;
        logic              busy;
    } exp_t;

    exp_t sbq[$];
    int   histI[$];
    int   histQ[$];
    int   mMode;
    int   mDelay;
    int   muteLeft;
    bit   mFirst;
    int   nCompared;
    int   nMismatched;

    function automatic int rndSample();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    // Model: the active config is whatever the cfg inputs held at the last
    // sample edge; any difference restarts a MUTE_LEN-sample zero window.
    // Loopback data is the DAC sample d writes ago from the history list.
    task automatic applyStimulus(input bit av, input int ai, input int aq,
                                 input bit dv, input int di, input int dq);
        exp_t e;
        int   li;
        int   lq;
        bit   srcV;
        int   d;
        adc_valid = av;
        adc_i     = ai[DATA_W-1:0];
        adc_q     = aq[DATA_W-1:0];
        dac_valid = dv;
        dac_i     = di[DATA_W-1:0];
        dac_q     = dq[DATA_W-1:0];
        d         = int'(cfg_delay);
        if (mFirst) begin
            mMode  = int'(cfg_mode);
            mDelay = d;
            mFirst = 1'b0;
        end else if (int'(cfg_mode) != mMode || d != mDelay) begin
            mMode    = int'(cfg_mode);
            mDelay   = d;
            muteLeft = MUTE_LEN;
        end
        srcV = (mMode == 1) ? dv : av;
        if (srcV) begin
            li = 0;
            lq = 0;
            if (muteLeft > 0) begin
                muteLeft = muteLeft - 1;
                e.busy   = (muteLeft > 0);
            end else begin
                e.busy = 1'b0;
                if (mMode == 0) begin
                    li = ai;
                    lq = aq;
                end else if (mMode == 1) begin
                    if (d == 0) begin
                        li = di;
                        lq = dq;
                    end else if (histI.size() >= d) begin
                        li = histI[d-1];
                        lq = histQ[d-1];
                    end
                    li = li >>> int'(cfg_atten_shift);
                    lq = lq >>> int'(cfg_atten_shift);
                end
            end
            e.i = li[DATA_W-1:0];
            e.q = lq[DATA_W-1:0];
            sbq.push_back(e);
        end
        if (dv) begin
            histI.push_front(di);
            histQ.push_front(dq);
            if (histI.size() > DELAY_MAX) begin
                void'(histI.pop_back());
                void'(histQ.pop_back());
            end
        end
        @(posedge clk_32M768);
        #1;
        adc_valid = 1'b0;
        dac_valid = 1'b0;
    endtask

    task automatic checkOutput();
        exp_t e;
        nCompared = nCompared + 1;
        if (sbq.size() == 0) begin
            nMismatched = nMismatched + 1;
            $display("[TB] FAIL unexpected_valid: out_valid=1 i=%0h q=%0h, required no output", out_i, out_q);
        end else begin
            e = sbq.pop_front();
            if (out_i !== e.i || out_q !== e.q || sw_busy !== e.busy) begin
                nMismatched = nMismatched + 1;
                $display("[TB] FAIL sample @%0t: got i=%0h q=%0h busy=%0b, required i=%0h q=%0h busy=%0b",
                         $time, out_i, out_q, sw_busy, e.i, e.q, e.busy);
            end
        end
    endtask

    always @(negedge clk_32M768) begin
        if (!rst_32M768 && out_valid) begin
            checkOutput();
        end
    end

    task automatic doReset();
        @(negedge clk_32M768);
        #1;
        rst_32M768 = 1'b1;
        adc_valid  = 1'b0;
        dac_valid  = 1'b0;
        #1;
        nCompared = nCompared + 1;
        if (out_valid !== 1'b0 || out_i !== '0 || out_q !== '0 || sw_busy !== 1'b1) begin
            nMismatched = nMismatched + 1;
            $display("[TB] FAIL reset_state: got v=%0b i=%0h q=%0h busy=%0b, required v=0 i=0 q=0 busy=1",
                     out_valid, out_i, out_q, sw_busy);
        end
        repeat (2) @(posedge clk_32M768);
        #1;
        rst_32M768 = 1'b0;
        histI.delete();
        histQ.delete();
        muteLeft = MUTE_LEN;
        mFirst   = 1'b1;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nCompared       = 0;
        nMismatched     = 0;
        muteLeft        = MUTE_LEN;
        mFirst          = 1'b1;
        mMode           = 0;
        mDelay          = 0;
        rst_32M768      = 1'b1;
        cfg_mode        = MODE_ADC;
        cfg_delay       = '0;
        cfg_atten_shift = '0;
        adc_valid       = 1'b0;
        dac_valid       = 1'b0;
        adc_i           = '0;
        adc_q           = '0;
        dac_i           = '0;
        dac_q           = '0;
        doReset();

        $display("[TB] ADC pass-through after reset");
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b1, k, -k, 1'b0, 0, 0);
        end

        $display("[TB] loopback d=5 with gaps and ignored ADC valids");
        cfg_mode  = MODE_LOOP;
        cfg_delay = 6'd5;
        for (int k = 0; k < 46; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(1'b1, rndSample(), rndSample(), 1'b0, 0, 0);
            end
            applyStimulus(1'($urandom_range(0, 1)), rndSample(), rndSample(), 1'b1, 100 + k, -(100 + k));
        end

        $display("[TB] attenuation");
        cfg_delay       = 6'd0;
        cfg_atten_shift = 4'd2;
        for (int k = 0; k < MUTE_LEN; k++) begin
            applyStimulus(1'b0, 0, 0, 1'b1, -8, 8);
        end
        applyStimulus(1'b0, 0, 0, 1'b1, -8, 8);
        cfg_atten_shift = 4'd15;
        applyStimulus(1'b0, 0, 0, 1'b1, -8, 8);
        applyStimulus(1'b0, 0, 0, 1'b1, 8, -8);
        cfg_atten_shift = 4'd0;

        $display("[TB] delay change 5 -> 7 while running");
        cfg_delay = 6'd5;
        for (int k = 0; k < 30; k++) begin
            applyStimulus(1'b0, 0, 0, 1'b1, rndSample(), rndSample());
        end
        cfg_delay = 6'd7;
        for (int k = 0; k < 30; k++) begin
            applyStimulus(1'b0, 0, 0, 1'b1, rndSample(), rndSample());
        end

        $display("[TB] mode change during mute");
        cfg_delay = 6'd3;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 0, 0, 1'b1, rndSample(), rndSample());
        end
        cfg_mode = MODE_ADC;
        for (int k = 0; k < 22; k++) begin
            applyStimulus(1'b1, rndSample(), rndSample(), 1'($urandom_range(0, 1)), rndSample(), rndSample());
        end

        $display("[TB] reset mid-loopback");
        cfg_mode = MODE_LOOP;
        for (int k = 0; k < 25; k++) begin
            applyStimulus(1'b0, 0, 0, 1'b1, rndSample(), rndSample());
        end
        doReset();
        for (int k = 0; k < 22; k++) begin
            applyStimulus(1'b0, 0, 0, 1'b1, rndSample(), rndSample());
        end

        $display("[TB] random traffic");
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 39) == 0) cfg_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) cfg_delay = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) cfg_atten_shift = 4'($urandom_range(0, 15));
            if (k == 300) doReset();
            applyStimulus(1'($urandom_range(0, 1)), rndSample(), rndSample(),
                          1'($urandom_range(0, 2) != 0), rndSample(), rndSample());
        end

        repeat (3) @(posedge clk_32M768);
        nCompared = nCompared + 1;
        if (sbq.size() != 0) begin
            nMismatched = nMismatched + 1;
            $display("[TB] FAIL drain: %0d expected outputs never appeared, required 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
